// File: rtl/spi_bitrev_pkg.sv
// Shared types and helpers for the bit-reversing SPI slave.
// Holds the FSM state type, synchroniser idle levels and the word reverse function.
package spi_bitrev_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRx,
        StTx
    } bitrev_state_t;

    localparam logic SYNC_IDLE_SS   = 1'b1;
    localparam logic SYNC_IDLE_MOSI = 1'b1;

    // Reverses the low w bits of d; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev_f(input logic [31:0] d, input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < w) begin
                r[5'(i)] = d[5'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser followed by a registered level/edge stage.
// Reset loads the idle level everywhere so releasing reset never fakes an edge.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, level_q, rise_q, fall_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_q    <= RST_VAL;
            s2_q    <= RST_VAL;
            level_q <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= d_i;
            s2_q    <= s1_q;
            level_q <= s2_q;
            rise_q  <= s2_q & ~level_q;
            fall_q  <= ~s2_q & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_bitrev_slave.sv
// Oversampling SPI slave: receives a word LSB-first, then returns its bit reverse
// LSB-first within the same chip select. Supports back-to-back frames and abort detection.
module spi_bitrev_slave
    import spi_bitrev_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter bit          CPOL   = 1'b0,
    parameter bit          CPHA   = 1'b0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              abort
);

    localparam int unsigned          CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]     LAST  = CNT_W'(DATA_W - 1);

    logic sck_lvl, sck_rise, sck_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_sync_edge #(.RST_VAL(CPOL)) u_sync_sck (
        .clock   (clock),
        .reset_n (reset_n),
        .d_i     (sck),
        .level_o (sck_lvl),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    spi_sync_edge #(.RST_VAL(SYNC_IDLE_SS)) u_sync_ss (
        .clock   (clock),
        .reset_n (reset_n),
        .d_i     (ss),
        .level_o (ss_lvl),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    spi_sync_edge #(.RST_VAL(SYNC_IDLE_MOSI)) u_sync_mosi (
        .clock   (clock),
        .reset_n (reset_n),
        .d_i     (mosi),
        .level_o (mosi_lvl),
        .rise_o  (mosi_rise),
        .fall_o  (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sck_lvl, ss_fall, mosi_rise, mosi_fall};

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    assign lead_edge   = CPOL ? sck_fall : sck_rise;
    assign trail_edge  = CPOL ? sck_rise : sck_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    bitrev_state_t     state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shreg_q, rx_data_q, shreg_in;
    logic              miso_q, rx_valid_q, abort_q;

    assign shreg_in = {mosi_lvl, shreg_q[DATA_W-1:1]};

    // In TX, shreg holds the reversed word and shifts it out from bit 0.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shreg_q    <= '0;
            rx_data_q  <= '0;
            miso_q     <= 1'b1;
            rx_valid_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            abort_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    miso_q <= 1'b1;
                    cnt_q  <= '0;
                    if (!ss_lvl) state_q <= StRx;
                end
                StRx: begin
                    if (ss_rise) begin
                        abort_q <= (cnt_q != '0);
                        state_q <= StIdle;
                        miso_q  <= 1'b1;
                        shreg_q <= '0;
                        cnt_q   <= '0;
                    end else if (sample_edge) begin
                        if (cnt_q == LAST) begin
                            rx_data_q  <= shreg_in;
                            rx_valid_q <= 1'b1;
                            shreg_q    <= DATA_W'(bitrev_f(32'(shreg_in), DATA_W));
                            cnt_q      <= '0;
                            state_q    <= StTx;
                        end else begin
                            shreg_q <= shreg_in;
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end else if (shift_edge) begin
                        miso_q <= 1'b1;
                    end
                end
                StTx: begin
                    if (ss_rise) begin
                        abort_q <= 1'b1;
                        state_q <= StIdle;
                        miso_q  <= 1'b1;
                        shreg_q <= '0;
                        cnt_q   <= '0;
                    end else if (sample_edge) begin
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            state_q <= StRx;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (shift_edge) begin
                        miso_q  <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign abort    = abort_q;

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// Self-checking bench: an 8-bit mode-0 slave and a 16-bit mode-3 slave driven by a
// behavioural SPI master, compared against a plain-arithmetic bit-reverse model.
module tb_spi_bitrev_slave;

    localparam int H = 10;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  sck = 2'b10;
    logic [1:0]  ss = 2'b11;
    logic [1:0]  mosi = 2'b11;
    logic        miso0, miso1, rx_valid0, rx_valid1, abort0, abort1;
    logic [7:0]  rx_data8;
    logic [15:0] rx_data16;

    always #5 clock = ~clock;

    spi_bitrev_slave #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0)) u_dut8 (
        .clock    (clock),
        .reset_n  (reset_n),
        .sck      (sck[0]),
        .ss       (ss[0]),
        .mosi     (mosi[0]),
        .miso     (miso0),
        .rx_data  (rx_data8),
        .rx_valid (rx_valid0),
        .abort    (abort0)
    );

    spi_bitrev_slave #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1)) u_dut16 (
        .clock    (clock),
        .reset_n  (reset_n),
        .sck      (sck[1]),
        .ss       (ss[1]),
        .mosi     (mosi[1]),
        .miso     (miso1),
        .rx_data  (rx_data16),
        .rx_valid (rx_valid1),
        .abort    (abort1)
    );

    int checks = 0;
    int errors = 0;
    int vcnt0 = 0, vcnt1 = 0, acnt0 = 0, acnt1 = 0;
    logic [31:0] rxq0[$];
    logic [31:0] rxq1[$];

    always @(negedge clock) begin
        if (rx_valid0) begin vcnt0++; rxq0.push_back(32'(rx_data8)); end
        if (rx_valid1) begin vcnt1++; rxq1.push_back(32'(rx_data16)); end
        if (abort0) acnt0++;
        if (abort1) acnt1++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_rev(input logic [31:0] w, input int n);
        logic [31:0] r;
        r = 0;
        for (int i = 0; i < n; i++) begin
            if (((w >> i) & 32'd1) != 0) r = r | (32'd1 << (n - 1 - i));
        end
        return r;
    endfunction

    function automatic int vcnt(input int u);
        return (u == 0) ? vcnt0 : vcnt1;
    endfunction

    function automatic int acnt(input int u);
        return (u == 0) ? acnt0 : acnt1;
    endfunction

    function automatic logic [31:0] last_rx(input int u, input int back);
        if (u == 0) return (rxq0.size() > back) ? rxq0[rxq0.size() - 1 - back] : 32'hdeadbeef;
        return (rxq1.size() > back) ? rxq1[rxq1.size() - 1 - back] : 32'hdeadbeef;
    endfunction

    function automatic logic get_miso(input int u);
        return (u == 0) ? miso0 : miso1;
    endfunction

    task automatic wait_clk(input int k);
        repeat (k) @(negedge clock);
    endtask

    // Master: each frame is DATA_W bits out on mosi then DATA_W bits captured from miso.
    task automatic xfer(input int u, input int nframes, input logic [31:0] w0,
                        input logic [31:0] w1, input int limit, input bit hold,
                        output logic [31:0] r0, output logic [31:0] r1, output logic ones);
        int n, total, f, k;
        logic cpol, cpha, bitv, got;
        logic [31:0] w;
        n = (u == 0) ? 8 : 16;
        cpol = (u == 1);
        cpha = (u == 1);
        total = (limit > 0) ? limit : nframes * 2 * n;
        r0 = 0;
        r1 = 0;
        ones = 1'b1;
        ss[u] = 1'b0;
        wait_clk(H);
        for (int s = 0; s < total; s++) begin
            f = s / (2 * n);
            k = s % (2 * n);
            w = (f == 0) ? w0 : w1;
            bitv = (k < n) ? (((w >> k) & 32'd1) != 0) : 1'b1;
            if (!cpha) begin
                mosi[u] = bitv;
                wait_clk(H);
                got = get_miso(u);
                sck[u] = ~cpol;
                wait_clk(H);
                sck[u] = cpol;
            end else begin
                sck[u] = ~cpol;
                mosi[u] = bitv;
                wait_clk(H);
                got = get_miso(u);
                sck[u] = cpol;
                wait_clk(H);
            end
            if (k < n) ones = ones & got;
            else if (f == 0) r0 = r0 | (32'(got) << (k - n));
            else r1 = r1 | (32'(got) << (k - n));
        end
        if (!hold) begin
            wait_clk(H);
            ss[u] = 1'b1;
            mosi[u] = 1'b1;
            wait_clk(2 * H);
        end
    endtask

    task automatic run_frame(input int u, input logic [31:0] w, input string tag);
        int n, v0, a0;
        logic [31:0] r0, r1;
        logic ones;
        n = (u == 0) ? 8 : 16;
        v0 = vcnt(u);
        a0 = acnt(u);
        xfer(u, 1, w, 0, 0, 1'b0, r0, r1, ones);
        check({tag, "_valid_pulses"}, 32'(vcnt(u) - v0), 1);
        check({tag, "_rx_data"}, last_rx(u, 0), w);
        check({tag, "_reply"}, r0, ref_rev(w, n));
        check({tag, "_miso_rx_idle"}, 32'(ones), 1);
        check({tag, "_no_abort"}, 32'(acnt(u) - a0), 0);
    endtask

    initial begin
        int v0, a0, v1, a1;
        logic [31:0] r0, r1, keep;
        logic ones, mhigh;

        wait_clk(3);
        check("rst_miso8", 32'(miso0), 1);
        check("rst_miso16", 32'(miso1), 1);
        check("rst_rx_data8", 32'(rx_data8), 0);
        check("rst_rx_data16", 32'(rx_data16), 0);
        check("rst_pulses", 32'({rx_valid0, rx_valid1, abort0, abort1}), 0);
        reset_n = 1'b1;
        wait_clk(5);

        run_frame(0, 32'h01, "m0_01");
        run_frame(1, 32'h1234, "m3_1234");

        // Back-to-back frames under one chip select.
        v0 = vcnt0;
        a0 = acnt0;
        xfer(0, 2, 32'hA5, 32'h0F, 0, 1'b0, r0, r1, ones);
        check("b2b_valid_pulses", 32'(vcnt0 - v0), 2);
        check("b2b_rx_first", last_rx(0, 1), 32'hA5);
        check("b2b_rx_second", last_rx(0, 0), 32'h0F);
        check("b2b_reply_first", r0, ref_rev(32'hA5, 8));
        check("b2b_reply_second", r1, ref_rev(32'h0F, 8));
        check("b2b_no_abort", 32'(acnt0 - a0), 0);

        // Chip select raised after 5 received bits.
        v0 = vcnt0;
        a0 = acnt0;
        keep = 32'(rx_data8);
        xfer(0, 1, 32'h5A, 0, 5, 1'b0, r0, r1, ones);
        check("abort_pulses", 32'(acnt0 - a0), 1);
        check("abort_no_valid", 32'(vcnt0 - v0), 0);
        check("abort_rx_kept", 32'(rx_data8), keep);
        run_frame(0, 32'h3C, "after_abort");

        // Reset mid-TX, three reply bits in; 0x0F drives zeros at that point.
        xfer(0, 1, 32'h0F, 0, 11, 1'b1, r0, r1, ones);
        wait_clk(6);
        v0 = vcnt0;
        a0 = acnt0;
        a1 = acnt1;
        reset_n = 1'b0;
        wait_clk(1);
        check("midrst_miso", 32'(miso0), 1);
        check("midrst_rx_data", 32'(rx_data8), 0);
        wait_clk(1);
        reset_n = 1'b1;
        ss[0] = 1'b1;
        mosi[0] = 1'b1;
        wait_clk(4 * H);
        check("midrst_no_abort", 32'(acnt0 - a0 + acnt1 - a1), 0);
        check("midrst_no_valid", 32'(vcnt0 - v0), 0);
        run_frame(0, 32'h80, "after_rst");

        // sck activity with ss high must be ignored.
        v0 = vcnt0; a0 = acnt0; v1 = vcnt1; a1 = acnt1;
        mhigh = 1'b1;
        for (int e = 0; e < 20; e++) begin
            sck = ~sck;
            for (int c = 0; c < 6; c++) begin
                @(negedge clock);
                mhigh = mhigh & miso0 & miso1;
            end
        end
        wait_clk(2 * H);
        check("ss_high_miso", 32'(mhigh), 1);
        check("ss_high_pulses", 32'((vcnt0 - v0) + (acnt0 - a0) + (vcnt1 - v1) + (acnt1 - a1)), 0);

        for (int i = 0; i < 6; i++) run_frame(0, 32'($urandom_range(0, 255)), "rnd8");
        for (int i = 0; i < 3; i++) run_frame(1, 32'($urandom_range(0, 65535)), "rnd16");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_bitrev_slave.md
# spi_bitrev_slave

Parametrised SPI slave peripheral model for the SoC's SPI test path. It runs entirely in the system clock domain and oversamples `sck`/`ss`/`mosi`. It receives a `DATA_W`-bit word LSB-first, then returns its bit-reversed value on `miso` within the same chip-select assertion. Over the previous bit-reverse model it adds width/mode parameters, back-to-back frames, a received-word strobe and abort detection. It sits behind the SPI master as its loopback target.

## Interface
- `DATA_W`, 8: frame width in bits; legal 4..32.
- `CPOL`, 0: sck idle level.
- `CPHA`, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `sck`  in  1  SPI clock, asynchronous to `clock`.
- `ss`  in  1  slave select, active-low, asynchronous.
- `mosi`  in  1  serial data in, asynchronous.
- `miso`  out  1  serial data out, registered; idles 1.
- `rx_data`  out  DATA_W  last fully received word.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `abort`  out  1  one-cycle pulse when `ss` rises mid-frame.

## Operation
- Synchroniser: `sck`, `ss` and `mosi` each pass through 2 flops, then one edge-detect register.
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other one.
- States: IDLE, RX, TX.
- IDLE: `miso`=1, bit counter = 0.
  - Synchronised `ss` low → RX.
  - Edges seen while `ss` is high are ignored.
- RX:
  - Each sample edge: `shreg <= {mosi_s, shreg[DATA_W-1:1]}`, counter +1. The first bit received becomes bit 0 of word W.
  - Shift edges drive `miso`=1.
  - On the DATA_W-th sample: `rx_data <= W` (the post-shift value), `rx_valid` pulses next cycle, counter → 0, state → TX.
- TX:
  - Output word is R = bit-reverse(W), sent LSB-first, i.e. W[DATA_W-1] first.
  - Each shift edge drives the next bit of R. The first TX shift edge is the first shift edge after the last RX sample.
  - Each sample edge increments the counter.
  - On the DATA_W-th TX sample edge → RX, counter → 0. `ss` still low means a back-to-back frame; the next shift edge drives `miso`=1.
- Synchronised `ss` rising:
  - In RX with counter ≠ 0, or in TX: `abort` pulses, state → IDLE, `miso`=1, `shreg` and counter cleared, `rx_data` kept.
  - In RX with counter = 0: silent return to IDLE.
- `ss` rising in the same cycle as a sample edge: the `ss` event wins; the edge is discarded.
- Reset (`reset_n` low at a `clock` edge, at any time including mid-frame): state IDLE, `miso`=1, `rx_data`=0, `rx_valid`=0, `abort`=0, counter 0, `shreg` 0.
  - Synchroniser flops load their idle values: sck=CPOL, ss=1, mosi=1. This prevents a spurious edge on release.
  - No `abort` pulse is generated by reset.

## Timing
- Input to internal edge event: 3 `clock` cycles. `miso` updates 4 `clock` cycles after the `sck` pin edge.
- Requirement: `sck` high and low phases ≥ 8 `clock` cycles each, so `miso` settles before the master samples.
- Requirement: `ss` setup to first `sck` edge ≥ 4 `clock` cycles.
- `rx_valid` is asserted for exactly 1 cycle, the cycle after the DATA_W-th RX sample is registered.
- `abort` is asserted for exactly 1 cycle.
- Counter width is `$clog2(DATA_W+1)`. No wrap occurs within a phase.

## Structure
- Package `spi_bitrev_pkg` holds:
  - state enum `bitrev_state_t` (IDLE, RX, TX);
  - function `bitrev_f` (parametric reverse);
  - localparams for synchroniser idle values.
- Sub-module `spi_sync_edge`, instantiated 3 times: 2-flop synchroniser plus edge-detect register, parameter `RST_VAL`, outputs level, rise and fall.
- Edge-role selection (sample/shift) is combinational from CPOL/CPHA in the top level.

## Test plan
- DATA_W=8, CPOL=0/CPHA=0, send 0x01 → `rx_valid` pulse with `rx_data`=0x01; master captures 0x80 (bits 0,0,0,0,0,0,0,1); `miso`=1 during RX.
- DATA_W=16, CPOL=1/CPHA=1, send 0x1234 → `rx_data`=0x1234; master captures 0x2C48.
- DATA_W=8, mode 0, two frames under one `ss` low: 0xA5 then 0x0F → two `rx_valid` pulses; replies 0xA5 and 0xF0; no `abort`.
- Raise `ss` after 5 RX bits → `abort` pulses once, `rx_data` unchanged. Next full frame 0x3C → reply 0x3C.
- Assert `reset_n`=0 for 2 cycles mid-TX → `miso`=1 and `rx_data`=0 the cycle after the reset edge, no `abort`; a subsequent frame of 0x80 returns 0x01.
- Toggle `sck` with `ss` high for 20 edges → no state change, `miso` stays 1, no pulses.
